// File: rtl/four_port_bus_arbiter_pkg.sv
// Shared types and constants for the four-port round-robin bus arbiter.
package four_port_bus_arbiter_pkg;

  localparam int unsigned NumReq = 4;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  localparam logic [1:0] ReqIdx0 = 2'd0;
  localparam logic [1:0] ReqIdx1 = 2'd1;
  localparam logic [1:0] ReqIdx2 = 2'd2;
  localparam logic [1:0] ReqIdx3 = 2'd3;

endpackage

// File: rtl/four_port_bus_arbiter_if.sv
// Requester/bus signal bundle; master is the arbiter's view, slave the environment's view.
interface four_port_bus_arbiter_if #(
  parameter int unsigned DWIDTH = 64
);
  logic [3:0]        Req;
  logic [DWIDTH-1:0] Req_data_1;
  logic [DWIDTH-1:0] Req_data_2;
  logic [DWIDTH-1:0] Req_data_3;
  logic [DWIDTH-1:0] Req_data_4;
  logic              Bus_done;
  logic              Bus_valid;
  logic [DWIDTH-1:0] Bus_data;
  logic [1:0]        Sel;
  logic [3:0]        Grant;
  logic [3:0]        Done;
  logic [3:0]        Err;

  modport master (
    input  Req, Req_data_1, Req_data_2, Req_data_3, Req_data_4, Bus_done,
    output Bus_valid, Bus_data, Sel, Grant, Done, Err
  );

  modport slave (
    output Req, Req_data_1, Req_data_2, Req_data_3, Req_data_4, Bus_done,
    input  Bus_valid, Bus_data, Sel, Grant, Done, Err
  );
endinterface

// File: rtl/four_port_bus_arbiter_four_to_1_mux.sv
// Payload steering mux: select index 0..3 picks input 1..4.
module four_to_1_mux
  import four_port_bus_arbiter_pkg::*;
#(
  parameter int unsigned DWIDTH = 64
) (
  input  logic [1:0]        sel_i,
  input  logic [DWIDTH-1:0] in_1_i,
  input  logic [DWIDTH-1:0] in_2_i,
  input  logic [DWIDTH-1:0] in_3_i,
  input  logic [DWIDTH-1:0] in_4_i,
  output logic [DWIDTH-1:0] data_o
);

  always_comb begin
    data_o = '0;
    unique case (sel_i)
      ReqIdx0: data_o = in_1_i;
      ReqIdx1: data_o = in_2_i;
      ReqIdx2: data_o = in_3_i;
      ReqIdx3: data_o = in_4_i;
    endcase
  end

endmodule

// File: rtl/four_port_bus_arbiter.sv
// Round-robin arbiter sharing one bus among four requesters with done/timeout handshake.
module four_port_bus_arbiter
  import four_port_bus_arbiter_pkg::*;
#(
  parameter int unsigned DWIDTH  = 64,
  parameter int unsigned TIMEOUT = 16
) (
  input logic                     clk,
  input logic                     reset,
  four_port_bus_arbiter_if.master bus
);

  localparam int unsigned   CntW   = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  // First asserted request searching last+1, last+2, last+3, last.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] win;
    win = last;
    for (int k = NumReq; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) win = idx;
    end
    return win;
  endfunction

  state_e          state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic [3:0]      grant_q, grant_d;
  logic [1:0]      last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic       bus_valid;
  logic [3:0] done;
  logic [3:0] err;
  logic [1:0] winner;

  assign winner = rr_pick(bus.Req, last_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      sel_q   <= ReqIdx0;
      grant_q <= '0;
      last_q  <= ReqIdx3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    bus_valid = 1'b0;
    done      = '0;
    err       = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.Req != 4'b0000) begin
          sel_d   = winner;
          grant_d = 4'b0001 << winner;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        bus_valid = 1'b1;
        if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
        // Done takes priority over a timeout landing in the same cycle.
        if (bus.Bus_done) begin
          done    = grant_q;
          last_d  = sel_q;
          grant_d = '0;
          state_d = StIdle;
        end else if (cnt_q == CntMax) begin
          err     = grant_q;
          last_d  = sel_q;
          grant_d = '0;
          state_d = StIdle;
        end
      end
    endcase

    // A reset-aborted transaction must not report completion or timeout.
    if (reset) begin
      done = '0;
      err  = '0;
    end
  end

  assign bus.Bus_valid = bus_valid;
  assign bus.Sel       = sel_q;
  assign bus.Grant     = grant_q;
  assign bus.Done      = done;
  assign bus.Err       = err;

  four_to_1_mux #(
    .DWIDTH (DWIDTH)
  ) u_mux (
    .sel_i  (sel_q),
    .in_1_i (bus.Req_data_1),
    .in_2_i (bus.Req_data_2),
    .in_3_i (bus.Req_data_3),
    .in_4_i (bus.Req_data_4),
    .data_o (bus.Bus_data)
  );

endmodule

// File: doc/four_port_bus_arbiter.md
# four_port_bus_arbiter

Round-robin arbiter that shares one downstream bus port (e.g. the data-memory interface) among four requesters. It sequences each transaction with a grant/done handshake and a per-transaction timeout. It drives the select of an internal four_to_1_mux that steers the winning requester's payload onto the shared bus. It sits between the core's memory-side masters (fetch, load/store, debug, DMA) and the single memory port.

## Interface
- DWIDTH, 64, payload width per requester and on the bus
- TIMEOUT, 16, maximum BUSY cycles allowed before abort; must be ≥ 2
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- Req  in  4  per-requester request; bit i belongs to requester i
- Req_data_1 … Req_data_4  in  DWIDTH each  requester payloads (address/data/command)
- Bus_done  in  1  downstream completion, valid only while Bus_valid=1
- Bus_valid  out  1  transaction in progress on the shared bus
- Bus_data  out  DWIDTH  payload of the granted requester
- Sel  out  2  index of the granted requester; drives the mux select
- Grant  out  4  one-hot grant; all-zero when idle
- Done  out  4  one-hot completion strobe to the owning requester
- Err  out  4  one-hot timeout strobe to the owning requester

## Operation
- States: IDLE, BUSY.
- Round-robin pointer `last` (2 bits) holds the most recently granted index.
- IDLE:
  - If Req≠0, the winner is the first asserted bit searching last+1, last+2, last+3, last (mod 4).
  - Register Sel=winner and Grant=onehot(winner), clear the counter, go to BUSY.
  - If Req=0, stay in IDLE with all outputs idle.
- BUSY:
  - Bus_valid=1; Bus_data=Req_data_(Sel+1) through the mux; the counter increments each cycle.
  - Bus_done=1: Done=Grant in the same cycle (combinational). At the edge, last←Sel, Grant←0, go to IDLE.
  - Else if the counter reaches TIMEOUT-1: Err=Grant in the same cycle. At the edge, last←Sel, go to IDLE.
  - Bus_done and timeout in the same cycle: Done wins and Err stays 0.
- Req of the granted requester dropping during BUSY is ignored; the transaction runs to Done or Err. Requesters hold Req_data stable until Done or Err.
- Done, Err and Bus_valid are zero in IDLE. Done and Err are never both nonzero.
- Counter width is $clog2(TIMEOUT); the counter saturates and never wraps inside BUSY.
- Bus_done while in IDLE is ignored.

## Timing
- Reset values: state=IDLE, Sel=0, Grant=0, last=3 (requester 0 wins first), counter=0, Bus_valid=0, Done=0, Err=0.
- Reset asserted mid-BUSY aborts the transaction on the next edge with no Done or Err pulse.
- Grant latency: Req seen in IDLE in cycle n produces Grant/Bus_valid in cycle n+1.
- Bus_done in cycle m produces Done in cycle m, IDLE in m+1, and the next grant at the earliest in m+2 (one mandatory bubble).
- Timeout: Err appears in the TIMEOUT-th consecutive BUSY cycle.
- Sel and Grant are stable for the entire BUSY interval.
- Bus_data is combinational from Sel and Req_data, with no added latency.

## Structure
- Shared package: state encoding (IDLE=1'b0, BUSY=1'b1) and the requester index constants 0–3.
- One sub-module: four_to_1_mux (DWIDTH passed through), with Sel driving its select and inputs 1–4 mapped to Req_data_1–4.
- The winner-search function, pointer, counter and FSM live in the top module.

## Test plan
- Reset: hold reset 2 cycles with Req=4'b1111 → all outputs 0 and Grant=0 throughout. First grant after release goes to requester 0.
- Single request: Req=4'b0100, Bus_done high on the 3rd BUSY cycle → Sel=2, Grant=4'b0100, Bus_data=Req_data_3, Done=4'b0100 for exactly 1 cycle.
- Fairness: Req=4'b1111 held, Bus_done=1 on each first BUSY cycle → grant order 0,1,2,3,0, one IDLE cycle between grants.
- Timeout: TIMEOUT=16, Req=4'b0010, Bus_done never asserted → Err=4'b0010 in BUSY cycle 16, Done stays 0, IDLE next cycle.
- Collision: Bus_done rises exactly on BUSY cycle 16 → Done pulses, Err stays 0.
- Abort and ignore: reset during BUSY with Req=4'b1000 → IDLE next cycle, no Done or Err, last=3. Separately, dropping Req mid-BUSY still yields Done.
